bsr_pipe: RTL and testbench
===========================

Name: bsr_pipe

Overview:
Pipelined barrel rotate-right. It is the inverse-direction companion to the team's combinational rotate-left stage block. It accepts an N-bit word and a rotate amount through a valid/ready handshake and applies one power-of-two rotation per registered stage. It returns the word rotated right by the amount, with full throughput and backpressure. It sits between streaming producer/consumer blocks where a combinational N-wide rotator would limit clock rate.

Parameters:
N, 8, data width in bits; power of two, N >= 2
W, $clog2(N), rotate-amount width and number of pipeline stages

Ports:
iClk  input  1  clock, all state updates on rising edge
iRst_n  input  1  reset, asynchronous assert, active-low
iValid  input  1  input word/amount valid
oReady  output  1  block can accept input this cycle
iA  input  N  word to rotate
iAmt  input  W  rotate-right amount, 0..N-1
oValid  output  1  oY holds a result
iReady  input  1  downstream accepts oY this cycle
oY  output  N  iA rotated right by iAmt

Behaviour:
- Function: oY = (A >> s) | (A << (N-s)), mod-N rotate. Bits shifted out of bit 0 re-enter at bit N-1. s=0 passes A unchanged.
- W register stages, S0..S(W-1). Each stage holds valid bit v[k], data d[k] (N bits) and remaining amount a[k] (W bits).
- Input capture: on handshake (iValid & oReady), S0 loads iA rotated right by 2^0 if iAmt[0] is set, else iA unrotated. S0 also stores iAmt.
- Stage k (k >= 1) loads from S(k-1). It rotates right by 2^k if a[k-1][k] is set, else passes the data through. It copies a[k-1].
- Output: oY = d[W-1], oValid = v[W-1]. No combinational path from iA to oY.
- Latency: a result appears on oY W cycles after its input handshake if iReady stays high. N=8 gives 3 cycles.
- Throughput: one word per cycle with sustained iValid and iReady.
- Advance rule (bubble-collapsing):
  - en[W-1] = ~v[W-1] | iReady
  - en[k] = ~v[k] | en[k+1]
  - oReady = en[0]
  - When en[k] is high, stage k loads v[k-1] (S0 loads iValid & oReady) and the matching data/amount.
  - Ready is combinational from iReady through the valid bits only.
- Stall: with iReady low and the pipe full, no stage changes. oY and oValid hold stable. oReady is low.
- Simultaneous output accept and input accept in the same cycle: both occur, and no item is lost or duplicated.
- Ordering: strict FIFO order. No reordering, no drops.
- iValid low with the pipe draining: bubbles propagate. oValid drops after the last item is accepted.
- Data register contents for invalid stages are don't-care internally. oY is driven from d[W-1] regardless of oValid.
- Reset (asynchronous, iRst_n low):
  - all v[k] = 0, all d[k] = 0, all a[k] = 0
  - so oValid = 0, oY = 0, and oReady = 1 as soon as reset is released
- Reset mid-operation discards all in-flight items. The first post-reset result comes only from a post-reset handshake.
- iAmt values are always in range (W bits, N a power of two). No saturation or error path.

Test Plan:
- N=8, iA=0x81, iAmt=1, iReady=1 -> oValid high exactly 3 cycles after handshake, oY=0xC0. Then iA=0x81, iAmt=0 -> oY=0x81. Then iA=0x01, iAmt=7 -> oY=0x02.
- N=8, 8 back-to-back inputs iA=0x01, iAmt=0..7, iReady=1 -> outputs on 8 consecutive cycles: 0x01, 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02.
- Backpressure:
  - iReady=0 while pushing 4 items -> 3 are accepted, then oReady=0 and oY stable.
  - Raise iReady -> all items emerge in order.
  - The 4th item is accepted the same cycle the first one leaves, with no loss or duplication.
- Reset with 3 items in flight, iRst_n low for one cycle mid-clock -> oValid and oY go 0 immediately, oReady=1 after release, and no stale item is ever output.
- N=16, iA=0x1234, iAmt=4 -> oY=0x4123. iAmt=15 -> oY=0x2468.
- Random 1000 vectors, random iValid/iReady throttling, N=8 and N=16 -> every oY matches a scoreboard model of the rotate-right, in order. Rotating the result left by the same amount recovers iA.

Source files
------------

// File: rtl/bsr_pipe.sv
// ---------------------------------------------------------------------------
// bsr_pipe : pipelined barrel rotate-right
//
// Rotates an N-bit word right by a W-bit amount (W = $clog2(N)), applying
// one power-of-two rotation per registered stage. Stage k rotates by 2^k
// when bit k of the carried amount is set. A valid/ready handshake runs on
// both ends, and stalled stages are skipped by bubble-collapsing advance
// enables. Throughput is one word per cycle, and latency is W cycles.
// This block is the right-rotating counterpart of the combinational
// rotate-left stage block.
//
// Ports:
//   iClk    - clock, all state changes on the rising edge
//   iRst_n  - asynchronous active-low reset, clears every stage
//   iValid  - iA/iAmt carry a word to accept
//   oReady  - block accepts a word this cycle (combinational from iReady)
//   iA      - word to rotate
//   iAmt    - rotate-right amount, 0..N-1
//   oValid  - oY holds a result
//   iReady  - downstream accepts oY this cycle
//   oY      - iA rotated right by iAmt (driven from the last stage)
// ---------------------------------------------------------------------------
module bsr_pipe #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iValid,
    output logic         oReady,
    input  logic [N-1:0] iA,
    input  logic [W-1:0] iAmt,
    output logic         oValid,
    input  logic         iReady,
    output logic [N-1:0] oY
);

    // Per-stage state: valid flag, partially rotated data, full amount.
    logic [W-1:0] v;
    logic [N-1:0] d [W];
    logic [W-1:0] a [W];

    // Advance enable per stage.
    logic [W-1:0] en;

    // Mod-N rotate right by sh. Bits leaving bit 0 re-enter at bit N-1.
    // sh is always below N here, and a shift by N yields zero, which keeps
    // sh = 0 a pass-through.
    function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int unsigned sh);
        return (x >> sh) | (x << (N - sh));
    endfunction

    // Bubble-collapsing advance. A stage may load when any stage from
    // itself to the output is empty, or when the consumer is taking the
    // output word. This is the unrolled form of
    // en[k] = ~v[k] | en[k+1] with en[W-1] = ~v[W-1] | iReady.
    // It is written without en feeding back into itself, so the ready
    // chain depends only on iReady and the valid bits.
    always_comb begin
        logic acc;
        acc = 1'b0;
        en  = '0;
        for (int k = 0; k < W; k++) begin
            acc = iReady;
            for (int j = k; j < W; j++) begin
                acc = acc | ~v[j];
            end
            en[k] = acc;
        end
    end

    // The input side is ready exactly when the first stage can advance.
    assign oReady = en[0];

    // Pipeline registers.
    // Stage 0 captures the input word, pre-rotated by 1 when iAmt[0] is
    // set. Stage k then applies the 2^k step selected by bit k of the
    // amount carried alongside the data. A stage whose enable is low
    // holds everything, so a full pipe with iReady low freezes. An
    // enabled stage whose predecessor is empty loads a bubble. Stage 0
    // loads iValid when enabled, because oReady equals en[0], so a word
    // is only captured on a real handshake.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            v <= '0;
            for (int k = 0; k < W; k++) begin
                d[k] <= '0;
                a[k] <= '0;
            end
        end else begin
            if (en[0]) begin
                v[0] <= iValid;
                d[0] <= iAmt[0] ? rotr(iA, 1) : iA;
                a[0] <= iAmt;
            end
            for (int k = 1; k < W; k++) begin
                if (en[k]) begin
                    v[k] <= v[k-1];
                    d[k] <= a[k-1][k] ? rotr(d[k-1], 1 << k) : d[k-1];
                    a[k] <= a[k-1];
                end
            end
        end
    end

    // Outputs come straight from the last stage register, so there is no
    // combinational path from iA to oY.
    assign oY     = d[W-1];
    assign oValid = v[W-1];

endmodule

// File: tb/tb_bsr_pipe.sv
// ---------------------------------------------------------------------------
// tb_bsr_pipe : self-checking bench for bsr_pipe
//
// Instantiates an 8-bit and a 16-bit pipe on a shared clock and reset.
// A per-instance scoreboard queue holds every accepted word and amount.
// Each emitted word is compared, in order, against a bit-by-bit rotate
// model, and is rotated back left to confirm the original word returns.
// oReady is checked every cycle against an occupancy rule: the pipe
// accepts unless all W stages are full and the consumer is stalling.
// Directed steps cover latency, back-to-back flow, backpressure and reset,
// followed by randomized traffic with throttling on both sides.
// ---------------------------------------------------------------------------
module tb_bsr_pipe;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  amt;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v8, r8o, ov8, ir8;
    logic [7:0]  a8, y8;
    logic [2:0]  amt8;

    logic        v16, r16o, ov16, ir16;
    logic [15:0] a16, y16;
    logic [3:0]  amt16;

    int nCompared   = 0;
    int nMismatched = 0;
    int cycleNo     = 0;
    int nAcc8       = 0;
    int nAcc16      = 0;

    item_t       q8[$];
    item_t       q16[$];
    logic [15:0] log8[$];
    logic [15:0] log16[$];
    int          stamp8[$];

    bsr_pipe #(.N(8)) dut8 (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iValid (v8),
        .oReady (r8o),
        .iA     (a8),
        .iAmt   (amt8),
        .oValid (ov8),
        .iReady (ir8),
        .oY     (y8)
    );

    bsr_pipe #(.N(16)) dut16 (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iValid (v16),
        .oReady (r16o),
        .iA     (a16),
        .iAmt   (amt16),
        .oValid (ov16),
        .iReady (ir16),
        .oY     (y16)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Safety net so the run always ends even if a loop misbehaves.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference rotate right of the low n bits: output bit i takes input
    // bit (i+s) mod n.
    function automatic logic [15:0] refRotr(input logic [15:0] x, input int s, input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = x[(i + s) % n];
        return r;
    endfunction

    // Reference rotate left of the low n bits: input bit i lands at
    // (i+s) mod n.
    function automatic logic [15:0] refRotl(input logic [15:0] x, input int s, input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[(i + s) % n] = x[i];
        return r;
    endfunction

    // One comparison: counts it, and on mismatch counts the failure and
    // reports the tag with observed and expected values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Carry the inputs driven since the last falling edge across one
    // rising edge. Just before the edge, score the output handshake
    // against the model, record the input handshake, and check oReady
    // against the occupancy rule. Returns at the next falling edge, which
    // is where callers drive new inputs.
    task automatic applyStimulus();
        item_t e;
        #2;
        checkOutput("ready8", r8o, (q8.size() < 3 || ir8) ? 1 : 0);
        if (ov8 && ir8) begin
            if (q8.size() == 0) begin
                checkOutput("spurious8", 1, 0);
            end else begin
                e = q8.pop_front();
                checkOutput("data8", y8, refRotr(e.a, int'(e.amt), 8));
                checkOutput("inverse8", refRotl({8'h00, y8}, int'(e.amt), 8), e.a);
                log8.push_back({8'h00, y8});
                stamp8.push_back(cycleNo);
            end
        end
        if (v8 && r8o) begin
            q8.push_back('{a: {8'h00, a8}, amt: {1'b0, amt8}});
            nAcc8++;
        end

        checkOutput("ready16", r16o, (q16.size() < 4 || ir16) ? 1 : 0);
        if (ov16 && ir16) begin
            if (q16.size() == 0) begin
                checkOutput("spurious16", 1, 0);
            end else begin
                e = q16.pop_front();
                checkOutput("data16", y16, refRotr(e.a, int'(e.amt), 16));
                checkOutput("inverse16", refRotl(y16, int'(e.amt), 16), e.a);
                log16.push_back(y16);
            end
        end
        if (v16 && r16o) begin
            q16.push_back('{a: a16, amt: amt16});
            nAcc16++;
        end

        @(negedge clk);
        cycleNo++;
    endtask

    // Push one word into the 8-bit pipe and measure the number of rising
    // edges, counting the handshake edge, until oValid rises.
    task automatic latency8(input logic [7:0] a, input logic [2:0] amt, input logic [7:0] exp);
        int lat;
        a8 = a; amt8 = amt; v8 = 1'b1; ir8 = 1'b1;
        applyStimulus();
        v8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 10) begin
            applyStimulus();
            lat++;
        end
        checkOutput("latency8", lat, 3);
        checkOutput("direct8", y8, exp);
        applyStimulus();
    endtask

    task automatic latency16(input logic [15:0] a, input logic [3:0] amt, input logic [15:0] exp);
        int lat;
        a16 = a; amt16 = amt; v16 = 1'b1; ir16 = 1'b1;
        applyStimulus();
        v16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 10) begin
            applyStimulus();
            lat++;
        end
        checkOutput("latency16", lat, 4);
        checkOutput("direct16", y16, exp);
        applyStimulus();
    endtask

    initial begin
        logic [7:0] hold;
        logic [7:0] expB2b [8];
        logic [7:0] expBp  [4];
        int cycles;

        expB2b = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
        expBp  = '{8'hC0, 8'h60, 8'h30, 8'h18};

        rst_n = 1'b0;
        v8 = 1'b0; ir8 = 1'b0; a8 = '0; amt8 = '0;
        v16 = 1'b0; ir16 = 1'b0; a16 = '0; amt16 = '0;

        // Reset state
        #3;
        checkOutput("reset_ovalid8", ov8, 0);
        checkOutput("reset_y8", y8, 0);
        checkOutput("reset_ovalid16", ov16, 0);
        checkOutput("reset_y16", y16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_ready8", r8o, 1);
        checkOutput("reset_ready16", r16o, 1);
        @(negedge clk);

        // Single-word latency and basic rotations, N=8
        latency8(8'h81, 3'd1, 8'hC0);
        latency8(8'h81, 3'd0, 8'h81);
        latency8(8'h01, 3'd7, 8'h02);

        // Eight back-to-back words, one result per cycle
        log8.delete(); stamp8.delete();
        ir8 = 1'b1; v8 = 1'b1; a8 = 8'h01;
        for (int i = 0; i < 8; i++) begin
            amt8 = 3'(i);
            applyStimulus();
        end
        v8 = 1'b0;
        repeat (5) applyStimulus();
        checkOutput("b2b_count", log8.size(), 8);
        for (int i = 0; i < 8 && i < log8.size(); i++) begin
            checkOutput("b2b_value", log8[i], {8'h00, expB2b[i]});
            checkOutput("b2b_consecutive", stamp8[i] - stamp8[0], i);
        end

        // Backpressure: three words fill the pipe and the fourth waits
        log8.delete();
        ir8 = 1'b0; v8 = 1'b1; a8 = 8'h81;
        amt8 = 3'd1; applyStimulus();
        amt8 = 3'd2; applyStimulus();
        amt8 = 3'd3; applyStimulus();
        amt8 = 3'd4;
        #1;
        checkOutput("bp_ready_low", r8o, 0);
        checkOutput("bp_ovalid", ov8, 1);
        checkOutput("bp_front", y8, 8'hC0);
        hold = y8;
        applyStimulus();
        applyStimulus();
        checkOutput("bp_stable_y", y8, hold);
        checkOutput("bp_stable_ovalid", ov8, 1);
        checkOutput("bp_still_low", r8o, 0);
        // Release: the first word leaves as the fourth enters
        ir8 = 1'b1;
        #1;
        checkOutput("bp_ready_high", r8o, 1);
        applyStimulus();
        v8 = 1'b0;
        repeat (6) applyStimulus();
        checkOutput("bp_count", log8.size(), 4);
        for (int i = 0; i < 4 && i < log8.size(); i++) begin
            checkOutput("bp_order", log8[i], {8'h00, expBp[i]});
        end
        checkOutput("bp_drained", q8.size(), 0);

        // Reset with three words in flight, asserted mid-cycle
        ir8 = 1'b0; v8 = 1'b1; a8 = 8'hA5;
        amt8 = 3'd1; applyStimulus();
        amt8 = 3'd2; applyStimulus();
        amt8 = 3'd3; applyStimulus();
        v8 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ovalid", ov8, 0);
        checkOutput("rst_y", y8, 0);
        q8.delete();
        q16.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready", r8o, 1);
        checkOutput("rst_ovalid_after", ov8, 0);
        @(negedge clk);
        log8.delete();
        ir8 = 1'b1;
        repeat (5) applyStimulus();
        checkOutput("rst_no_stale", log8.size(), 0);
        latency8(8'h81, 3'd2, 8'h60);

        // N=16 directed values
        latency16(16'h1234, 4'd4, 16'h4123);
        latency16(16'h1234, 4'd15, 16'h2468);

        // Randomized traffic with throttling on both handshakes
        cycles = 0;
        begin
            int base8, base16;
            base8 = nAcc8;
            base16 = nAcc16;
            while (((nAcc8 - base8) < 1000 || (nAcc16 - base16) < 1000) && cycles < 20000) begin
                v8    = ((nAcc8 - base8) < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
                a8    = 8'($urandom);
                amt8  = 3'($urandom);
                ir8   = ($urandom_range(0, 3) != 0);
                v16   = ((nAcc16 - base16) < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
                a16   = 16'($urandom);
                amt16 = 4'($urandom);
                ir16  = ($urandom_range(0, 3) != 0);
                applyStimulus();
                cycles++;
            end
        end
        checkOutput("rand_budget", (cycles < 20000) ? 1 : 0, 1);
        v8 = 1'b0; ir8 = 1'b1; v16 = 1'b0; ir16 = 1'b1;
        repeat (10) applyStimulus();
        checkOutput("rand_drain8", q8.size(), 0);
        checkOutput("rand_drain16", q16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
